instr_fetch_unit: RTL and testbench

// - Fetch stage directly upstream of the opcode decoder: owns the PC and fetches the instruction from the instruction

---
 rtl/instr_fetch_unit_pkg.sv | 27 ++
 rtl/instr_fetch_unit_next_pc_sel.sv | 28 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: PcSrc encodings,
// opcode constants, reset defaults and the fetch FSM state type.
package instr_fetch_unit_pkg;

    // Decoder PcSrc encodings
    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    // Opcode constants (instr[6:0]) of the control-flow instructions
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_TRAP
    } fsm_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection: sequential / branch / JALR mux, JALR LSB clear and
// misalignment detection on the selected target.
module next_pc_sel
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_src_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jalr_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    // Select the next PC; JALR clears bit 0 so only bit 1 can fault there
    always_comb begin
        pc_plus4_o = pc_i + 32'd4;
        unique case (pc_src_i)
            PCSRC_SEQ:  next_pc_o = pc_plus4_o;
            PCSRC_BR:   next_pc_o = branch_taken_i ? branch_target_i : pc_plus4_o;
            PCSRC_JALR: next_pc_o = jalr_target_i & ~32'd1;
            default:    next_pc_o = pc_plus4_o;
        endcase
        misalign_o = |next_pc_o[1:0];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a valid/ready request and response
// handshake, holds the instruction for decode until retire, counts retired
// instructions and traps on a misaligned next PC.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             retire,
    input  logic [1:0]       pc_src,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jalr_target,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired_cnt
);

    fsm_state_e       state_q, state_d;
    logic             armed_q;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      next_pc;
    logic [31:0]      pc_plus4_w;
    logic             next_misalign;
    logic             retire_fire;

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .pc_src_i        (pc_src),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jalr_target_i   (jalr_target),
        .pc_plus4_o      (pc_plus4_w),
        .next_pc_o       (next_pc),
        .misalign_o      (next_misalign)
    );

    assign retire_fire = (state_q == ST_EXEC) && retire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_REQ;
        else        state_q <= state_d;
    end

    // Request is suppressed until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_q <= 1'b0;
        else        armed_q <= 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ:  if (armed_q && imem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (imem_rsp_valid)            state_d = ST_EXEC;
            ST_EXEC: if (retire)                    state_d = next_misalign ? ST_TRAP : ST_REQ;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    // FSM outputs decoded from registered state only
    always_comb begin
        imem_req_valid = (state_q == ST_REQ) && armed_q;
        instr_valid    = (state_q == ST_EXEC);
    end

    // Datapath next values: instruction capture, PC update, error flag, counter
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        if ((state_q == ST_WAIT) && imem_rsp_valid) begin
            instr_d = imem_rsp_data;
        end
        if (retire_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (next_misalign) misalign_d = 1'b1;
            else               pc_d       = next_pc;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_w;
    assign instr        = instr_q;
    assign misalign_err = misalign_q;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: acts as instruction memory and
// datapath, and tracks expected PC/count/error in a behavioural model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] jalr_target = '0;
    logic        misalign_err;
    logic [31:0] retired_cnt;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .retire         (retire),
        .pc_src         (pc_src),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jalr_target    (jalr_target),
        .misalign_err   (misalign_err),
        .retired_cnt    (retired_cnt)
    );

    // Architectural next-PC rule
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic tk, input logic [31:0] bt,
                                             input logic [31:0] jt);
        if (src == 2'd2) return jt - (jt % 32'd2);
        if (src == 2'd1 && tk) return bt;
        return cur + 32'd4;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        retire = 1'b0; pc_src = 2'b00; branch_taken = 1'b0; branch_target = '0; jalr_target = '0;
        repeat (2) @(negedge clk);
        m_pc = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
    endtask

    // Wait for a request, optionally stall it, accept it, answer after lat cycles
    task automatic fetch(input logic [31:0] data, input int hold, input int lat);
        int n = 0;
        while (!imem_req_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (imem_req_valid !== 1'b1) $display("FAIL req_timeout got %b exp 1", imem_req_valid); else passes++;
        checks++; if (imem_addr !== m_pc) $display("FAIL fetch_addr got %h exp %h", imem_addr, m_pc); else passes++;
        for (int i = 0; i < hold; i++) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== m_pc)
                $display("FAIL req_hold got valid=%b addr=%h exp valid=1 addr=%h", imem_req_valid, imem_addr, m_pc);
            else passes++;
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL wait_req_low got %b exp 0", imem_req_valid); else passes++;
        for (int i = 0; i < lat; i++) begin
            retire = 1'($urandom_range(0, 1));
            checks++; if (instr_valid !== 1'b0) $display("FAIL wait_no_valid got %b exp 0", instr_valid); else passes++;
            @(negedge clk);
        end
        retire = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        checks++; if (instr_valid !== 1'b1) $display("FAIL exec_valid got %b exp 1", instr_valid); else passes++;
        checks++; if (instr !== data) $display("FAIL exec_instr got %h exp %h", instr, data); else passes++;
        checks++; if (pc !== m_pc) $display("FAIL exec_pc got %h exp %h", pc, m_pc); else passes++;
        checks++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL pc_plus4 got %h exp %h", pc_plus4, m_pc + 32'd4); else passes++;
        checks++; if (retired_cnt !== m_cnt) $display("FAIL cnt_after_fetch got %0d exp %0d", retired_cnt, m_cnt); else passes++;
    endtask

    // Retire the held instruction with the given control-flow inputs
    task automatic do_retire(input logic [1:0] src, input logic tk, input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] nxt;
        pc_src = src; branch_taken = tk; branch_target = bt; jalr_target = jt;
        retire = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        nxt = ref_next(m_pc, src, tk, bt, jt);
        m_cnt = m_cnt + 32'd1;
        if (nxt % 32'd4 != 32'd0) m_err = 1'b1;
        else m_pc = nxt;
        checks++; if (retired_cnt !== m_cnt) $display("FAIL retire_cnt got %0d exp %0d", retired_cnt, m_cnt); else passes++;
        checks++; if (misalign_err !== m_err) $display("FAIL misalign got %b exp %b", misalign_err, m_err); else passes++;
        if (m_err) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b1)
                    $display("FAIL trap_quiet got req=%b iv=%b err=%b exp req=0 iv=0 err=1",
                             imem_req_valid, instr_valid, misalign_err);
                else passes++;
                imem_req_ready = 1'b1;
                retire = 1'b1;
                @(negedge clk);
            end
            imem_req_ready = 1'b0;
            retire = 1'b0;
            checks++; if (pc !== m_pc) $display("FAIL trap_pc got %h exp %h", pc, m_pc); else passes++;
        end else begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0)
                $display("FAIL next_req got req=%b addr=%h iv=%b exp req=1 addr=%h iv=0",
                         imem_req_valid, imem_addr, instr_valid, m_pc);
            else passes++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc); else passes++;
        checks++; if (instr !== 32'h0000_0013) $display("FAIL rst_instr got %h exp 00000013", instr); else passes++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL rst_iv got %b exp 0", instr_valid); else passes++;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req_valid); else passes++;
        checks++; if (misalign_err !== 1'b0) $display("FAIL rst_err got %b exp 0", misalign_err); else passes++;
        checks++; if (retired_cnt !== 32'h0) $display("FAIL rst_cnt got %0d exp 0", retired_cnt); else passes++;
        imem_req_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);  // after 1st edge
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req_valid, imem_addr); else passes++;
        @(negedge clk);  // after 2nd edge: request accepted
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL first_wait got req=%b iv=%b exp 0 0", imem_req_valid, instr_valid); else passes++;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        @(negedge clk);  // after 3rd edge
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1) $display("FAIL first_iv got %b exp 1", instr_valid); else passes++;
        checks++; if (instr !== 32'h0050_0093) $display("FAIL first_instr got %h exp 00500093", instr); else passes++;
        checks++; if (retired_cnt !== 32'h0) $display("FAIL first_cnt got %0d exp 0", retired_cnt); else passes++;
    endtask

    task automatic test_seq();
        do_retire(2'b00, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_addr !== 32'h4 || retired_cnt !== 32'd1)
            $display("FAIL seq_addr got addr=%h cnt=%0d exp addr=4 cnt=1", imem_addr, retired_cnt); else passes++;
        fetch($urandom, 3, 1);
    endtask

    task automatic test_branch();
        do_retire(2'b01, 1'b1, 32'h10, 32'h0);
        fetch($urandom, 0, 0);
        do_retire(2'b01, 1'b1, 32'h40, 32'h0);
        checks++; if (imem_addr !== 32'h40) $display("FAIL br_taken got %h exp 40", imem_addr); else passes++;
        fetch($urandom, 1, 0);
        do_retire(2'b01, 1'b1, 32'h10, 32'h0);
        fetch($urandom, 0, 1);
        do_retire(2'b01, 1'b0, 32'h40, 32'h0);
        checks++; if (imem_addr !== 32'h14) $display("FAIL br_not_taken got %h exp 14", imem_addr); else passes++;
        fetch($urandom, 0, 0);
        do_retire(2'b11, 1'b1, 32'h80, 32'h0);
        checks++; if (imem_addr !== 32'h18) $display("FAIL src_reserved got %h exp 18", imem_addr); else passes++;
        fetch($urandom, 0, 0);
    endtask

    task automatic test_jalr();
        do_retire(2'b10, 1'b0, 32'h0, 32'h0000_0101);
        checks++; if (imem_addr !== 32'h100) $display("FAIL jalr_lsb got %h exp 100", imem_addr); else passes++;
        fetch($urandom, 0, 0);
        do_retire(2'b10, 1'b0, 32'h0, 32'h0000_0102);
        checks++; if (misalign_err !== 1'b1) $display("FAIL jalr_trap got %b exp 1", misalign_err); else passes++;
    endtask

    task automatic test_reset_midfetch();
        apply_reset();
        rst_n = 1'b1;
        fetch(32'h1111_1111, 0, 0);
        do_retire(2'b00, 1'b0, 32'h0, 32'h0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) $display("FAIL mid_wait got %b exp 0", imem_req_valid); else passes++;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        m_pc = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
        checks++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || pc !== 32'h0)
            $display("FAIL mid_rst got instr=%h iv=%b pc=%h exp 00000013 0 0", instr, instr_valid, pc); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0)
            $display("FAIL late_rsp got instr=%h iv=%b exp 00000013 0", instr, instr_valid); else passes++;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL restart got req=%b addr=%h exp 1 0", imem_req_valid, imem_addr); else passes++;
        fetch(32'h0050_0093, 0, 0);
    endtask

    task automatic test_wrap();
        do_retire(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFD);
        fetch($urandom, 0, 0);
        do_retire(2'b00, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_addr !== 32'h0 || misalign_err !== 1'b0)
            $display("FAIL wrap got addr=%h err=%b exp 0 0", imem_addr, misalign_err); else passes++;
        fetch($urandom, 0, 3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  src;
            logic [31:0] bt, jt;
            src = 2'($urandom_range(0, 3));
            bt  = $urandom & 32'hFFFF_FFFC;
            jt  = $urandom & 32'hFFFF_FFFD;
            do_retire(src, 1'($urandom_range(0, 1)), bt, jt);
            fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        do_retire(2'b01, 1'b1, ($urandom & 32'hFFFF_FFFC) | 32'h2, 32'h0);
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jalr();
        test_reset_midfetch();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
